// File: rtl/dram_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : dram_frame_reader
// Description : Streams whole frames from one of two DRAM frame buffers using
//               the read engine's kick/busy handshake. Returned words go
//               through an internal first-word-fall-through FIFO and leave as
//               a valid/ready stream tagged with start/end-of-frame markers.
// Revision    : 1.0 - initial parametrised multi-burst release
// ============================================================================
module dram_frame_reader #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned BURST_LEN   = 64,
  parameter int unsigned FRAME_WORDS = 1440000,
  parameter int unsigned FIFO_DEPTH  = 2048,
  parameter logic [31:0] BASE0       = 32'h0100_0000,
  parameter logic [31:0] BASE1       = 32'h0000_0000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic                        continuous_i,
  input  logic                        stop_i,
  input  logic                        frame_sel_i,
  output logic                        kick_o,
  input  logic                        busy_i,
  output logic [31:0]                 read_addr_o,
  output logic [31:0]                 read_num_o,
  input  logic [DATA_W-1:0]           rd_data_i,
  input  logic                        rd_we_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [DATA_W-1:0]           out_data_o,
  output logic                        out_sof_o,
  output logic                        out_eof_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt_o,
  output logic                        active_o,
  output logic                        frame_done_o,
  output logic                        err_extra_o
);

  localparam int unsigned c_AW = $clog2(FIFO_DEPTH);
  localparam int unsigned c_CW = c_AW + 1;
  localparam int unsigned c_OW = $clog2(FRAME_WORDS + 1);
  localparam int unsigned c_BW = $clog2(BURST_LEN + 1);
  localparam int unsigned c_EW = DATA_W + 2;

  localparam logic [c_OW-1:0] c_FRAME  = c_OW'(FRAME_WORDS);
  localparam logic [c_OW-1:0] c_LAST   = c_OW'(FRAME_WORDS - 1);
  localparam logic [c_CW-1:0] c_DEPTH  = c_CW'(FIFO_DEPTH);
  localparam logic [c_CW-1:0] c_CREDIT = c_CW'(BURST_LEN);
  localparam logic [31:0]     c_BPW    = 32'(DATA_W / 8);
  localparam logic [31:0]     c_BURST  = 32'(BURST_LEN);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_CHECK = 3'd1;
  localparam logic [2:0] c_REQ   = 3'd2;
  localparam logic [2:0] c_RECV  = 3'd3;
  localparam logic [2:0] c_DONE  = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [31:0]     base_q;
  logic [c_OW-1:0] offset_q;
  logic [c_BW-1:0] expected_q;
  logic [c_BW-1:0] rcv_q;
  logic            stop_pending_q;
  logic            err_q;

  logic [c_EW-1:0] mem_q [FIFO_DEPTH];
  logic [c_AW-1:0] wr_ptr_q;
  logic [c_AW-1:0] rd_ptr_q;
  logic [c_CW-1:0] cnt_q;

  logic [c_OW-1:0] w_remain;
  logic [31:0]     w_num;
  logic [31:0]     w_addr;
  logic [c_OW-1:0] w_offset_next;
  logic            w_credit_ok;
  logic            w_stop_seen;
  logic            w_frame_begin;
  logic            w_burst_end;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_reject;
  logic            w_full;
  logic            w_empty;
  logic            w_sof;
  logic            w_eof;
  logic [c_EW-1:0] w_head;

  // Request sizing, frame position and FIFO status
  always_comb begin
    w_remain      = c_FRAME - offset_q;
    w_num         = (32'(w_remain) < c_BURST) ? 32'(w_remain) : c_BURST;
    w_addr        = base_q + 32'(offset_q) * c_BPW;
    w_offset_next = offset_q + c_OW'(expected_q);
    w_full        = (cnt_q == c_DEPTH);
    w_empty       = (cnt_q == '0);
    w_credit_ok   = ((c_DEPTH - cnt_q) >= c_CREDIT);
    w_stop_seen   = stop_pending_q | stop_i;
    w_frame_begin = ((state_q == c_IDLE) && start_i) ||
                    ((state_q == c_DONE) && continuous_i && !w_stop_seen);
    w_burst_end   = (state_q == c_RECV) && (rcv_q == expected_q);
    // A word counts against the burst even if the FIFO cannot take it, so the
    // burst still terminates; the drop is flagged through err_extra instead.
    w_accept      = rd_we_i && (state_q == c_RECV) && (rcv_q != expected_q);
    w_push        = w_accept && !w_full;
    w_pop         = !w_empty && out_ready_i;
    // Stray words after a reset land in IDLE and are ignored without a flag.
    w_reject      = rd_we_i && (state_q != c_IDLE) && !w_push;
    w_sof         = (offset_q == '0) && (rcv_q == '0);
    w_eof         = ((offset_q + c_OW'(rcv_q)) == c_LAST);
    w_head        = mem_q[rd_ptr_q];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE: begin
        if (start_i) state_d = c_CHECK;
      end
      c_CHECK: begin
        if (w_credit_ok && !busy_i) state_d = c_REQ;
      end
      c_REQ: begin
        if (busy_i) state_d = c_RECV;
      end
      c_RECV: begin
        if (rcv_q == expected_q) begin
          state_d = (w_offset_next == c_FRAME) ? c_DONE : c_CHECK;
        end
      end
      c_DONE: begin
        state_d = (continuous_i && !w_stop_seen) ? c_CHECK : c_IDLE;
      end
      default: state_d = c_IDLE;
    endcase
  end

  // FSM outputs: request lines are only driven while requesting
  always_comb begin
    kick_o       = 1'b0;
    read_addr_o  = '0;
    read_num_o   = '0;
    frame_done_o = 1'b0;
    active_o     = (state_q != c_IDLE);
    case (state_q)
      c_REQ: begin
        kick_o      = 1'b1;
        read_addr_o = w_addr;
        read_num_o  = w_num;
      end
      c_DONE: frame_done_o = 1'b1;
      default: ;
    endcase
  end

  // Frame bookkeeping: buffer base, offset, burst counters, stop and error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q         <= '0;
      offset_q       <= '0;
      expected_q     <= '0;
      rcv_q          <= '0;
      stop_pending_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      if (w_frame_begin) begin
        base_q   <= frame_sel_i ? BASE1 : BASE0;
        offset_q <= '0;
      end
      if ((state_q == c_REQ) && busy_i) begin
        expected_q <= c_BW'(w_num);
        rcv_q      <= '0;
      end
      if (w_accept) rcv_q <= rcv_q + c_BW'(1);
      if (w_burst_end) offset_q <= w_offset_next;
      if (state_q == c_DONE) begin
        stop_pending_q <= 1'b0;
      end else if (stop_i && (state_q != c_IDLE)) begin
        stop_pending_q <= 1'b1;
      end
      if (w_reject) err_q <= 1'b1;
    end
  end

  // FIFO storage: {sof, eof, data} per entry, no reset needed on the array
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= {w_sof, w_eof, rd_data_i};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + c_AW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + c_AW'(1);
      case ({w_push, w_pop})
        2'b10:   cnt_q <= cnt_q + c_CW'(1);
        2'b01:   cnt_q <= cnt_q - c_CW'(1);
        default: ;
      endcase
    end
  end

  // Stream side: head of FIFO shown directly, forced to zero when empty
  always_comb begin
    out_valid_o = !w_empty;
    out_data_o  = w_empty ? '0 : w_head[DATA_W-1:0];
    out_sof_o   = !w_empty && w_head[DATA_W+1];
    out_eof_o   = !w_empty && w_head[DATA_W];
    fifo_cnt_o  = cnt_q;
    err_extra_o = err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_dram_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_dram_frame_reader
// Description : Directed self-checking bench for dram_frame_reader with a
//               small DRAM read-engine responder and an output stream monitor.
// Revision    : 1.0 - initial bench
// ============================================================================
module tb_dram_frame_reader;

  localparam int          DW = 32;
  localparam int          BL = 64;
  localparam int          FW = 200;
  localparam int          FD = 128;
  localparam logic [31:0] B0 = 32'h0100_0000;
  localparam logic [31:0] B1 = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic        stop = 1'b0;
  logic        frame_sel = 1'b0;
  logic        out_ready = 1'b0;
  logic        kick;
  logic        busy;
  logic [31:0] read_addr;
  logic [31:0] read_num;
  logic [31:0] rd_data;
  logic        rd_we;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_sof;
  logic        out_eof;
  logic [7:0]  fifo_cnt;
  logic        active;
  logic        frame_done;
  logic        err_extra;

  logic        eng_we;
  logic [31:0] eng_data;
  logic        inj_we = 1'b0;
  logic [31:0] inj_data = 32'h0;
  logic        eng_abort = 1'b0;
  int          extra_kick = -1;
  logic [31:0] data_ctr;

  logic [31:0] k_addr[$];
  logic [31:0] k_num[$];
  logic [31:0] mon_data[$];
  bit          mon_sof[$];
  bit          mon_eof[$];
  int          done_cnt = 0;

  int n_checks = 0;
  int n_err    = 0;

  assign rd_we   = eng_we | inj_we;
  assign rd_data = inj_we ? inj_data : eng_data;

  dram_frame_reader #(
    .DATA_W(DW), .BURST_LEN(BL), .FRAME_WORDS(FW), .FIFO_DEPTH(FD),
    .BASE0(B0), .BASE1(B1)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start), .continuous_i(continuous),
    .stop_i(stop), .frame_sel_i(frame_sel), .kick_o(kick), .busy_i(busy),
    .read_addr_o(read_addr), .read_num_o(read_num), .rd_data_i(rd_data),
    .rd_we_i(rd_we), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_sof_o(out_sof), .out_eof_o(out_eof),
    .fifo_cnt_o(fifo_cnt), .active_o(active), .frame_done_o(frame_done),
    .err_extra_o(err_extra)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  // DRAM engine: busy two cycles after a kick, then one word per cycle
  initial begin : engine
    logic [31:0] num;
    bit          extra;
    eng_we   = 1'b0;
    eng_data = 32'h0;
    busy     = 1'b0;
    data_ctr = 32'h1000_0000;
    forever begin
      @(posedge clk); #1;
      if (kick && !busy && !eng_abort) begin
        num = read_num;
        k_addr.push_back(read_addr);
        k_num.push_back(read_num);
        extra = ((k_addr.size() - 1) == extra_kick);
        repeat (2) begin @(posedge clk); #1; end
        if (!eng_abort) begin
          busy = 1'b1;
          @(posedge clk); #1;
          for (int i = 0; i < int'(num) && !eng_abort; i++) begin
            eng_we   = 1'b1;
            eng_data = data_ctr;
            data_ctr = data_ctr + 32'd1;
            @(posedge clk); #1;
          end
          if (extra && !eng_abort) begin
            eng_we   = 1'b1;
            eng_data = 32'hDEAD_BEEF;
            @(posedge clk); #1;
          end
        end
        eng_we = 1'b0;
        busy   = 1'b0;
      end
    end
  end

  // Stream monitor: record every handshake, count frame_done pulses
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      mon_data.push_back(out_data);
      mon_sof.push_back(out_sof);
      mon_eof.push_back(out_eof);
    end
    if (frame_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((active || out_valid) && n < 4000) begin tick(1); n++; end
    chk({tag, " idle_in_time"}, 64'(n < 4000), 1);
  endtask

  task automatic wait_kicks(input string tag, input int target);
    int n = 0;
    while (k_addr.size() < target && n < 2000) begin tick(1); n++; end
    chk({tag, " kick_in_time"}, 64'(n < 2000), 1);
  endtask

  task automatic wait_cnt(input string tag, input int target);
    int n = 0;
    while (int'(fifo_cnt) != target && n < 2000) begin tick(1); n++; end
    chk({tag, " cnt_in_time"}, 64'(n < 2000), 1);
  endtask

  task automatic chk_kick(input string tag, input int idx, input logic [31:0] a, input logic [31:0] num);
    logic [31:0] oa, on;
    oa = (idx < k_addr.size()) ? k_addr[idx] : 32'hFFFF_FFFF;
    on = (idx < k_num.size())  ? k_num[idx]  : 32'hFFFF_FFFF;
    chk({tag, " addr"}, oa, a);
    chk({tag, " num"},  on, num);
  endtask

  task automatic check_frame(input string tag, input int w0, input int nfr, input logic [31:0] d0);
    int nw, bd, bs, be;
    nw = mon_data.size() - w0;
    bd = 0; bs = 0; be = 0;
    chk({tag, " words"}, nw, nfr * FW);
    for (int i = 0; i < nw; i++) begin
      if (mon_data[w0+i] !== d0 + 32'(i)) bd++;
      if (mon_sof[w0+i] != ((i % FW) == 0)) bs++;
      if (mon_eof[w0+i] != ((i % FW) == FW - 1)) be++;
    end
    chk({tag, " data_order_bad"}, bd, 0);
    chk({tag, " sof_bad"}, bs, 0);
    chk({tag, " eof_bad"}, be, 0);
  endtask

  initial begin : main
    int k0, w0, dn0;
    logic [31:0] d0;

    // Reset state
    rst = 1'b1; tick(3);
    chk("rst kick", kick, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst fifo_cnt", fifo_cnt, 0);
    chk("rst active", active, 0);
    chk("rst err_extra", err_extra, 0);
    chk("rst frame_done", frame_done, 0);
    chk("rst read_addr", read_addr, 0);
    chk("rst read_num", read_num, 0);
    rst = 1'b0; tick(2);

    // Single frame from buffer 0, free-flowing output
    frame_sel = 1'b0; out_ready = 1'b1;
    k0 = k_addr.size(); w0 = mon_data.size(); d0 = data_ctr; dn0 = done_cnt;
    pulse_start();
    wait_idle("t1");
    chk("t1 kicks", k_addr.size() - k0, 4);
    chk_kick("t1 k0", k0 + 0, B0 + 32'd0,   32'd64);
    chk_kick("t1 k1", k0 + 1, B0 + 32'd256, 32'd64);
    chk_kick("t1 k2", k0 + 2, B0 + 32'd512, 32'd64);
    chk_kick("t1 k3", k0 + 3, B0 + 32'd768, 32'd8);
    chk("t1 frame_done", done_cnt - dn0, 1);
    check_frame("t1", w0, 1, d0);

    // Buffer 1 with a stalled sink: credit stops after two bursts
    frame_sel = 1'b1; out_ready = 1'b0;
    k0 = k_addr.size(); w0 = mon_data.size(); d0 = data_ctr; dn0 = done_cnt;
    pulse_start();
    wait_kicks("t2 two", k0 + 2);
    wait_cnt("t2 full", 128);
    tick(30);
    chk("t2 kicks stalled", k_addr.size() - k0, 2);
    chk("t2 fifo_cnt full", fifo_cnt, 128);
    chk_kick("t2 k0", k0 + 0, B1 + 32'd0,   32'd64);
    chk_kick("t2 k1", k0 + 1, B1 + 32'd256, 32'd64);
    out_ready = 1'b1; tick(63); out_ready = 1'b0;
    tick(20);
    chk("t2 fifo_cnt after 63 pops", fifo_cnt, 65);
    chk("t2 no third kick", k_addr.size() - k0, 2);
    out_ready = 1'b1; tick(1); out_ready = 1'b0;
    wait_kicks("t2 third", k0 + 3);
    chk_kick("t2 k2", k0 + 2, B1 + 32'd512, 32'd64);
    out_ready = 1'b1;
    wait_idle("t2");
    chk("t2 kicks", k_addr.size() - k0, 4);
    chk_kick("t2 k3", k0 + 3, B1 + 32'd768, 32'd8);
    chk("t2 frame_done", done_cnt - dn0, 1);
    check_frame("t2", w0, 1, d0);

    // Continuous mode, buffer switch between frames, stop during frame 2
    continuous = 1'b1; frame_sel = 1'b0; out_ready = 1'b1;
    k0 = k_addr.size(); w0 = mon_data.size(); d0 = data_ctr; dn0 = done_cnt;
    pulse_start();
    wait_kicks("t3 f1", k0 + 2);
    frame_sel = 1'b1;
    wait_kicks("t3 f2", k0 + 6);
    stop = 1'b1; tick(1); stop = 1'b0;
    wait_idle("t3");
    continuous = 1'b0;
    chk("t3 active", active, 0);
    chk("t3 frame_done", done_cnt - dn0, 2);
    chk("t3 kicks", k_addr.size() - k0, 8);
    chk_kick("t3 k3", k0 + 3, B0 + 32'd768, 32'd8);
    chk_kick("t3 k4", k0 + 4, B1 + 32'd0,   32'd64);
    chk_kick("t3 k7", k0 + 7, B1 + 32'd768, 32'd8);
    check_frame("t3", w0, 2, d0);

    // Stray words in IDLE are silently dropped
    frame_sel = 1'b0; tick(2);
    for (int i = 0; i < 3; i++) begin
      inj_we = 1'b1; inj_data = 32'hBAD0_0000 + 32'(i); tick(1);
      inj_we = 1'b0; tick(1);
    end
    chk("t4 idle err_extra", err_extra, 0);
    chk("t4 idle fifo_cnt", fifo_cnt, 0);
    chk("t4 idle out_valid", out_valid, 0);

    // One extra word after the first burst: dropped and flagged
    out_ready = 1'b0;
    extra_kick = k_addr.size();
    k0 = k_addr.size(); w0 = mon_data.size(); d0 = data_ctr; dn0 = done_cnt;
    pulse_start();
    wait_kicks("t4 two", k0 + 2);
    wait_cnt("t4 full", 128);
    tick(10);
    chk("t4 err_extra set", err_extra, 1);
    chk("t4 fifo_cnt", fifo_cnt, 128);
    out_ready = 1'b1;
    wait_idle("t4");
    extra_kick = -1;
    check_frame("t4", w0, 1, d0);
    chk("t4 err_extra sticky", err_extra, 1);

    // Reset in the middle of a burst
    out_ready = 1'b0; frame_sel = 1'b0;
    pulse_start();
    wait_cnt("t5 thirty", 30);
    eng_abort = 1'b1; rst = 1'b1; tick(1); rst = 1'b0;
    chk("t5 kick", kick, 0);
    chk("t5 out_valid", out_valid, 0);
    chk("t5 fifo_cnt", fifo_cnt, 0);
    chk("t5 active", active, 0);
    chk("t5 err_extra cleared", err_extra, 0);
    tick(4); eng_abort = 1'b0;
    inj_we = 1'b1; inj_data = 32'hBAD1_0000; tick(1); inj_we = 1'b0; tick(1);
    chk("t5 late word err_extra", err_extra, 0);
    chk("t5 late word fifo_cnt", fifo_cnt, 0);
    out_ready = 1'b1;
    k0 = k_addr.size(); w0 = mon_data.size(); d0 = data_ctr; dn0 = done_cnt;
    pulse_start();
    wait_idle("t5");
    chk("t5 kicks", k_addr.size() - k0, 4);
    chk_kick("t5 k0", k0 + 0, B0 + 32'd0, 32'd64);
    chk("t5 frame_done", done_cnt - dn0, 1);
    check_frame("t5", w0, 1, d0);

    // Simultaneous push and pop keeps the occupancy constant
    out_ready = 1'b0;
    k0 = k_addr.size(); w0 = mon_data.size(); d0 = data_ctr;
    pulse_start();
    wait_cnt("t6 ten", 10);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk($sformatf("t6 fifo_cnt step%0d", i), fifo_cnt, 10);
    end
    wait_idle("t6");
    check_frame("t6", w0, 1, d0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
